// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start, 8 data bits LSB-first, odd parity, stop, ACK check.
// Latency: pads change one clk after accept; data bits follow device clock falls by about 4 clk.
// Backpressure: tx_ready is high only in IDLE; tx_valid outside IDLE is dropped, nothing is queued.
// Optional watchdog on device clock edges: define PS2_HOST_TX_TIMEOUT_EN (otherwise timeout_err is tied 0).
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ = 65_000_000,
  parameter int INHIBIT_US  = 100,
  parameter int TIMEOUT_US  = 15000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam int         INH_CYC  = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
  localparam int         TO_CYC   = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam logic [23:0] INH_LOAD = 24'(INH_CYC - 1);
  localparam logic [23:0] TO_LOAD  = 24'(TO_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RELEASE,
    S_XFER,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  clk_sync_q, clk_sync_d;
  logic [1:0]  data_sync_q, data_sync_d;
  logic        clk_prev_q, clk_prev_d;
  logic [9:0]  shift_q, shift_d;
  logic [23:0] cnt_q, cnt_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic        nack_q, nack_d;
  logic        clk_oe_q, clk_oe_d;
  logic        data_oe_q, data_oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ack_err_q, ack_err_d;
  logic        timeout_err_q, timeout_err_d;
  logic        fe;

`ifdef PS2_HOST_TX_TIMEOUT_EN
  logic [23:0] to_cnt_q, to_cnt_d;
`else
  // Watchdog reload value has no consumer in this build.
  logic unused_to_load;
  assign unused_to_load = ^TO_LOAD;
`endif

  // Falling edge of the synchronized device clock (prev high, now low).
  assign fe       = clk_prev_q & ~clk_sync_q[1];
  assign tx_ready = (state_q == S_IDLE);

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_err     = ack_err_q;
  assign timeout_err = timeout_err_q;

  // Next-state logic: synchronizers, request sequencing, bit shifting and result pulses.
  always_comb begin
    state_d       = state_q;
    clk_sync_d    = {clk_sync_q[0], ps2_clk_in};
    data_sync_d   = {data_sync_q[0], ps2_data_in};
    clk_prev_d    = clk_sync_q[1];
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    bitcnt_d      = bitcnt_q;
    nack_d        = nack_q;
    clk_oe_d      = clk_oe_q;
    data_oe_d     = data_oe_q;
    done_d        = 1'b0;
    ack_err_d     = 1'b0;
    timeout_err_d = 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          // Stop bit, odd parity, then the byte; bit 0 goes out first.
          shift_d  = {1'b1, ~^tx_data, tx_data};
          cnt_d    = INH_LOAD;
          clk_oe_d = 1'b1;
          nack_d   = 1'b0;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == 24'd0) begin
          data_oe_d = 1'b1;
          state_d   = S_RELEASE;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      S_RELEASE: begin
        clk_oe_d = 1'b0;
        bitcnt_d = 4'd0;
        state_d  = S_XFER;
`ifdef PS2_HOST_TX_TIMEOUT_EN
        to_cnt_d = TO_LOAD;
`endif
      end
      S_XFER: begin
        if (fe) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[9:1]};
          bitcnt_d  = bitcnt_q + 4'd1;
          // Tenth fall has just released the line for the stop bit.
          if (bitcnt_q == 4'd9) begin
            state_d = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (fe) begin
          nack_d  = data_sync_q[1];
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_sync_q[1] && data_sync_q[1]) begin
          done_d    = ~nack_q;
          ack_err_d = nack_q;
          state_d   = S_IDLE;
        end
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
    // Watchdog between device clock falls; expiry abandons the transfer.
    if (state_q == S_XFER || state_q == S_ACK) begin
      if (fe) begin
        to_cnt_d = TO_LOAD;
      end else if (to_cnt_q == 24'd0) begin
        clk_oe_d      = 1'b0;
        data_oe_d     = 1'b0;
        timeout_err_d = 1'b1;
        state_d       = S_IDLE;
      end else begin
        to_cnt_d = to_cnt_q - 24'd1;
      end
    end
`endif

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset releases both pads immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      clk_sync_q    <= 2'b11;
      data_sync_q   <= 2'b11;
      clk_prev_q    <= 1'b1;
      shift_q       <= '0;
      cnt_q         <= '0;
      bitcnt_q      <= '0;
      nack_q        <= 1'b0;
      clk_oe_q      <= 1'b0;
      data_oe_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ack_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      to_cnt_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      clk_sync_q    <= clk_sync_d;
      data_sync_q   <= data_sync_d;
      clk_prev_q    <= clk_prev_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      bitcnt_q      <= bitcnt_d;
      nack_q        <= nack_d;
      clk_oe_q      <= clk_oe_d;
      data_oe_q     <= data_oe_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      ack_err_q     <= ack_err_d;
      timeout_err_q <= timeout_err_d;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: an open-collector device model clocks bytes out of the host.
// The device clock runs far faster than a real PS/2 device to keep the run short.
// The watchdog is shortened to 20 us (1300 clk) so the timeout build stays short too.
module tb_ps2_host_tx;

  localparam int HALF     = 40;
  localparam int TB_TO_US = 20;
  localparam int TO_CYC   = 65 * TB_TO_US;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, done, ack_err, timeout_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int ack_cnt = 0;
  int to_cnt = 0;
  int inh_cycles;
  int t_fe;
  logic [9:0] pad_bits;

  // Wired-AND pads: either side can pull low.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .CLK_FREQ_HZ(65_000_000),
    .INHIBIT_US (100),
    .TIMEOUT_US (TB_TO_US)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .ack_err    (ack_err),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (ack_err) ack_cnt++;
    if (timeout_err) to_cnt++;
  end

  // Requests byte b, then plays the device: 11 clock falls, ACK on the 11th.
  // glitch_fe / rst_fe / stop_fe select a disturbance after that fall (0 = none).
  task automatic run_byte(input logic [7:0] b, input logic ack_low, input int glitch_fe,
                          input int rst_fe, input int stop_fe);
    int n;
    int extra;
    pad_bits = '0;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = ~b;
    inh_cycles = 0;
    n = 0;
    while (!ps2_data_oe && n < 20000) begin
      if (ps2_clk_oe) inh_cycles++;
      n++;
      @(negedge clk);
    end
    if (n >= 20000) begin
      checks++; failures++;
      $display("FAIL start_bit_wait: data_oe never asserted within %0d cycles", n);
      return;
    end
    n = 0;
    while (ps2_clk_oe && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL clk_release_wait: clk_oe still 1 after %0d cycles", n);
      return;
    end
    for (int i = 1; i <= 11; i++) begin
      repeat (HALF) @(negedge clk);
      if (i == 11) dev_data = ~ack_low;
      dev_clk = 1'b0;
      if (i == stop_fe) t_fe = cyc;
      repeat (8) @(negedge clk);
      if (i <= 10) pad_bits[i-1] = ~ps2_data_oe;
      extra = 0;
      if (i == glitch_fe) begin
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        checks++;
        if (tx_ready !== 1'b0 || busy !== 1'b1) begin
          failures++;
          $display("FAIL glitch_ready: tx_ready=%b busy=%b, required 0 and 1", tx_ready, busy);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = ~b;
        extra = 1;
      end
      if (i == rst_fe) begin
        rst = 1'b1;
        #1;
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1) begin
          failures++;
          $display("FAIL rst_release: clk_oe=%b data_oe=%b tx_ready=%b, required 0 0 1",
                   ps2_clk_oe, ps2_data_oe, tx_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        dev_clk = 1'b1;
        dev_data = 1'b1;
        return;
      end
      repeat (HALF - 8 - extra) @(negedge clk);
      dev_clk = 1'b1;
      if (i == stop_fe) return;
    end
    dev_data = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_pads: clk_oe=%b data_oe=%b tx_ready=%b, required 0 0 1",
               ps2_clk_oe, ps2_data_oe, tx_ready);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, ack_err, timeout_err, tx_ready} !== 5'b00001) begin
      failures++;
      $display("FAIL reset_flags: busy/done/ack_err/timeout_err/tx_ready=%b, required 00001",
               {busy, done, ack_err, timeout_err, tx_ready});
    end
  endtask

  task automatic test_f4();
    int d0, a0;
    d0 = done_cnt; a0 = ack_cnt;
    run_byte(8'hF4, 1'b1, 0, 0, 0);
    checks++;
    if (pad_bits !== 10'b10_1111_0100) begin
      failures++;
      $display("FAIL f4_bits: pad bits=%b, required %b", pad_bits, 10'b10_1111_0100);
    end
    checks++;
    if (done_cnt - d0 != 1 || ack_cnt - a0 != 0) begin
      failures++;
      $display("FAIL f4_result: done=%0d ack_err=%0d, required 1 0", done_cnt - d0, ack_cnt - a0);
    end
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL f4_idle: tx_ready=%b busy=%b, required 1 0", tx_ready, busy);
    end
  endtask

  task automatic test_ff();
    int d0;
    d0 = done_cnt;
    run_byte(8'hFF, 1'b1, 0, 0, 0);
    checks++;
    if (inh_cycles != 6500) begin
      failures++;
      $display("FAIL ff_inhibit: clk_oe low-time=%0d, required 6500", inh_cycles);
    end
    checks++;
    if (pad_bits[8] !== 1'b1) begin
      failures++;
      $display("FAIL ff_parity: parity pad=%b, required 1", pad_bits[8]);
    end
    checks++;
    if (pad_bits !== 10'b11_1111_1111) begin
      failures++;
      $display("FAIL ff_bits: pad bits=%b, required %b", pad_bits, 10'b11_1111_1111);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL ff_done: done=%0d, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_nack();
    int d0, a0;
    d0 = done_cnt; a0 = ack_cnt;
    run_byte(8'hED, 1'b0, 0, 0, 0);
    checks++;
    if (pad_bits !== 10'b11_1110_1101) begin
      failures++;
      $display("FAIL ed_bits: pad bits=%b, required %b", pad_bits, 10'b11_1110_1101);
    end
    checks++;
    if (ack_cnt - a0 != 1 || done_cnt - d0 != 0) begin
      failures++;
      $display("FAIL ed_nack: ack_err=%0d done=%0d, required 1 0", ack_cnt - a0, done_cnt - d0);
    end
  endtask

  task automatic test_ignore_busy();
    int d0;
    d0 = done_cnt;
    run_byte(8'h3C, 1'b1, 4, 0, 0);
    checks++;
    if (pad_bits !== 10'b11_0011_1100) begin
      failures++;
      $display("FAIL ignore_bits: pad bits=%b, required %b", pad_bits, 10'b11_0011_1100);
    end
    repeat (200) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_queue: done=%0d busy=%b, required 1 0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_reset_mid();
    int d0, a0, t0;
    d0 = done_cnt; a0 = ack_cnt; t0 = to_cnt;
    run_byte(8'h0F, 1'b1, 0, 5, 0);
    repeat (50) @(negedge clk);
    checks++;
    if (done_cnt != d0 || ack_cnt != a0 || to_cnt != t0) begin
      failures++;
      $display("FAIL rst_pulses: done=%0d ack_err=%0d timeout_err=%0d, required 0 0 0",
               done_cnt - d0, ack_cnt - a0, to_cnt - t0);
    end
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      failures++;
      $display("FAIL rst_after: tx_ready=%b busy=%b clk_oe=%b data_oe=%b, required 1 0 0 0",
               tx_ready, busy, ps2_clk_oe, ps2_data_oe);
    end
  endtask

`ifdef PS2_HOST_TX_TIMEOUT_EN
  task automatic test_timeout();
    int n, t0, d0, delta;
    t0 = to_cnt; d0 = done_cnt;
    run_byte(8'h55, 1'b1, 0, 0, 3);
    n = 0;
    while (!timeout_err && n < TO_CYC + 200) begin
      n++;
      @(negedge clk);
    end
    delta = cyc - t_fe;
    checks++;
    if (!timeout_err || delta < TO_CYC || delta > TO_CYC + 6) begin
      failures++;
      $display("FAIL timeout_time: timeout_err=%b cycles after fe3=%0d, required 1 within %0d..%0d",
               timeout_err, delta, TO_CYC, TO_CYC + 6);
    end
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      failures++;
      $display("FAIL timeout_release: clk_oe=%b data_oe=%b, required 0 0", ps2_clk_oe, ps2_data_oe);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (to_cnt - t0 != 1 || done_cnt != d0 || tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL timeout_pulse: timeout_err=%0d done=%0d tx_ready=%b, required 1 0 1",
               to_cnt - t0, done_cnt - d0, tx_ready);
    end
  endtask
`else
  task automatic test_timeout();
    checks++;
    if (to_cnt != 0 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL no_timeout: timeout_err pulses=%0d, required 0", to_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_f4();
    test_ff();
    test_nack();
    test_ignore_busy();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
